// File: rtl/parity_checker.sv
// parity_checker: serial receiver for an 8-bit frame (LSB first) followed by
// one parity bit. It rebuilds the byte, checks it against the parity sense
// captured at frame start, and signals completion with a one-cycle done pulse.
module parity_checker (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       odd_mode_i,
  input  logic       bit_in_i,
  input  logic       bit_valid_i,
  output logic [7:0] data_out_o,
  output logic       parity_ok_o,
  output logic       parity_error_o,
  output logic       done_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    PARITY
  } state_t;

  state_t     state_q;
  logic [3:0] count_q;
  logic [7:0] shiftReg_q;
  logic [7:0] shiftReg_d;
  logic       runPar_q;
  logic       runPar_d;
  logic       modeR_q;
  logic       parOk_d;
  logic [7:0] dataOut_q;
  logic       parityOk_q;
  logic       parityError_q;
  logic       done_q;
  logic       busy_q;

  // Next values for the shifter and running parity, plus the frame verdict
  // that would apply if the current bit were the parity bit.
  always_comb begin
    shiftReg_d = {bit_in_i, shiftReg_q[7:1]};
    runPar_d   = runPar_q ^ bit_in_i;
    parOk_d    = modeR_q ? runPar_d : ~runPar_d;
  end

  // Frame sequencer: all state and all outputs are registered here so that
  // done and busy come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      count_q       <= 4'd0;
      shiftReg_q    <= 8'h00;
      runPar_q      <= 1'b0;
      modeR_q       <= 1'b0;
      dataOut_q     <= 8'h00;
      parityOk_q    <= 1'b0;
      parityError_q <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            modeR_q    <= odd_mode_i;
            count_q    <= 4'd0;
            shiftReg_q <= 8'h00;
            runPar_q   <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RECV;
          end
        end
        RECV: begin
          if (bit_valid_i) begin
            shiftReg_q <= shiftReg_d;
            runPar_q   <= runPar_d;
            count_q    <= count_q + 4'd1;
            if (count_q == 4'd7) begin
              state_q <= PARITY;
            end
          end
        end
        PARITY: begin
          if (bit_valid_i) begin
            dataOut_q     <= shiftReg_q;
            parityOk_q    <= parOk_d;
            parityError_q <= ~parOk_d;
            done_q        <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out_o     = dataOut_q;
  assign parity_ok_o    = parityOk_q;
  assign parity_error_o = parityError_q;
  assign done_o         = done_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_parity_checker.sv
// tb_parity_checker: directed-vector bench for parity_checker. Expected
// results for every frame are worked out by hand and passed in explicitly.
module tb_parity_checker;

  logic       clk;
  logic       rst;
  logic       startI;
  logic       oddModeI;
  logic       bitInI;
  logic       bitValidI;
  logic [7:0] dataOutO;
  logic       parityOkO;
  logic       parityErrorO;
  logic       doneO;
  logic       busyO;

  int assertCount;
  int failCount;

  parity_checker dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (startI),
    .odd_mode_i     (oddModeI),
    .bit_in_i       (bitInI),
    .bit_valid_i    (bitValidI),
    .data_out_o     (dataOutO),
    .parity_ok_o    (parityOkO),
    .parity_error_o (parityErrorO),
    .done_o         (doneO),
    .busy_o         (busyO)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value and tally it.
  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge consume them, and return
  // at the following falling edge where outputs are stable.
  task automatic applyStimulus(input logic st, input logic odd, input logic b, input logic v);
    startI    = st;
    oddModeI  = odd;
    bitInI    = b;
    bitValidI = v;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full frame: start, 8 data bits LSB first, parity bit. Optional idle gaps
  // after every data bit; with noise set, gaps carry a start pulse and a
  // flipped bit_in, and odd_mode is toggled throughout the frame.
  task automatic sendFrame(input string tag, input logic [7:0] data, input logic par,
                           input logic odd, input int gaps, input logic noise,
                           input logic expOk);
    logic oddDrive;
    applyStimulus(1'b1, odd, 1'b1, 1'b1);
    checkOutput({tag, "_busyAfterStart"}, {7'd0, busyO}, 8'd1);
    for (int i = 0; i < 8; i++) begin
      oddDrive = (noise && (i % 2 == 1)) ? ~odd : odd;
      applyStimulus(1'b0, oddDrive, data[i], 1'b1);
      for (int g = 0; g < gaps; g++) begin
        applyStimulus(noise && (g == 0), noise ? ~odd : odd,
                      noise ? ~data[i] : data[i], 1'b0);
      end
    end
    checkOutput({tag, "_doneBeforeParity"}, {7'd0, doneO}, 8'd0);
    checkOutput({tag, "_busyBeforeParity"}, {7'd0, busyO}, 8'd1);
    applyStimulus(1'b0, noise ? ~odd : odd, par, 1'b1);
    checkOutput({tag, "_done"}, {7'd0, doneO}, 8'd1);
    checkOutput({tag, "_busyAtDone"}, {7'd0, busyO}, 8'd0);
    checkOutput({tag, "_data"}, dataOutO, data);
    checkOutput({tag, "_ok"}, {7'd0, parityOkO}, {7'd0, expOk});
    checkOutput({tag, "_err"}, {7'd0, parityErrorO}, {7'd0, ~expOk});
  endtask

  // Directed sequence covering reset, both parity senses, gaps, ignored
  // start, mid-frame reset and back-to-back frames.
  initial begin
    assertCount = 0;
    failCount   = 0;
    rst         = 1'b1;
    startI      = 1'b0;
    oddModeI    = 1'b0;
    bitInI      = 1'b0;
    bitValidI   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_data", dataOutO, 8'h00);
    checkOutput("reset_ok", {7'd0, parityOkO}, 8'd0);
    checkOutput("reset_err", {7'd0, parityErrorO}, 8'd0);
    checkOutput("reset_done", {7'd0, doneO}, 8'd0);
    checkOutput("reset_busy", {7'd0, busyO}, 8'd0);
    rst = 1'b0;

    // Strobes with no start are ignored in IDLE.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("idle_busy", {7'd0, busyO}, 8'd0);

    $display("[TB] even pass / even fail");
    sendFrame("evenPass", 8'hA5, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("evenPass_doneDrops", {7'd0, doneO}, 8'd0);
    checkOutput("evenPass_dataHeld", dataOutO, 8'hA5);
    sendFrame("evenFail", 8'hA5, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] odd mode with odd_mode toggling mid-frame");
    sendFrame("odd01", 8'h01, 1'b0, 1'b1, 0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    sendFrame("odd00", 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] gapped strobes with ignored start");
    sendFrame("gap3C", 8'h3C, 1'b0, 1'b0, 3, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("gap3C_noRestart", {7'd0, busyO}, 8'd0);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("preRst_busy", {7'd0, busyO}, 8'd1);
    checkOutput("preRst_data", dataOutO, 8'h3C);
    rst = 1'b1;
    #1;
    checkOutput("midRst_data", dataOutO, 8'h00);
    checkOutput("midRst_ok", {7'd0, parityOkO}, 8'd0);
    checkOutput("midRst_err", {7'd0, parityErrorO}, 8'd0);
    checkOutput("midRst_done", {7'd0, doneO}, 8'd0);
    checkOutput("midRst_busy", {7'd0, busyO}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("postRst_noDone", {7'd0, doneO}, 8'd0);
    end
    sendFrame("cleanFF", 8'hFF, 1'b0, 1'b0, 0, 1'b0, 1'b1);

    $display("[TB] back-to-back frames");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    sendFrame("b2b1", 8'h5A, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    sendFrame("b2b2", 8'h80, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("b2b2_doneDrops", {7'd0, doneO}, 8'd0);
    checkOutput("b2b2_dataHeld", dataOutO, 8'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
